pulse_stretcher: RTL and testbench

- Output-side counterpart to the board input conditioning.
- Inputs are filtered so short glitches are rejected. This block works the other way: it lengthens short internal event pulses (1+ cycles) so they are visible on board LEDs or other slow outputs.
- Each of BITS lanes is independently retriggerable. All lanes share one millisecond timebase.
- Sits between processor status/event strobes and the LED output pins.

---
 rtl/pulse_stretcher.sv | 63 ++++++
 tb/tb_pulse_stretcher.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Per-lane retriggerable pulse stretcher that makes short event strobes visible on LEDs.
// All lanes share one free-running millisecond tick.
module pulse_stretcher #(
   parameter int FRQ     = 50000000,
   parameter int HOLD_MS = 100,
   parameter int BITS    = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [BITS-1:0] DIN,
   output logic [BITS-1:0] DOUT,
   output logic            ACTIVE
);

   localparam int          TICKDIV   = FRQ / 1000;
   localparam logic [31:0] TICK_LAST = 32'(TICKDIV - 1);
   localparam logic [15:0] HOLD_VAL  = 16'(HOLD_MS);

   logic [31:0]            tick_cnt;
   logic                   tick;
   logic [BITS-1:0][15:0]  cnt;
   logic [BITS-1:0][15:0]  cnt_next;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 32'd1;
      end
   end

   // A live input reloads the lane even on a tick cycle, so holding DIN high freezes the countdown.
   always_comb begin
      cnt_next = cnt;
      for (int i = 0; i < BITS; i++) begin
         if (DIN[i]) begin
            cnt_next[i] = HOLD_VAL;
         end else if (tick && (cnt[i] != 16'd0)) begin
            cnt_next[i] = cnt[i] - 16'd1;
         end
      end
   end

   // DOUT is registered from the next counter value so it always equals (cnt != 0) without decode glitches.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt  <= '0;
         DOUT <= '0;
      end else begin
         cnt <= cnt_next;
         for (int i = 0; i < BITS; i++) begin
            DOUT[i] <= (cnt_next[i] != 16'd0);
         end
      end
   end

   assign ACTIVE = |DOUT;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with FRQ=8000 (8-cycle tick), HOLD_MS=3, BITS=4.
// Edge k is the k-th rising edge after reset release; outputs are sampled on the following falling edge.
module tb_pulse_stretcher;

   logic       CLK;
   logic       RESET;
   logic [3:0] DIN;
   logic [3:0] DOUT;
   logic       ACTIVE;

   int checks   = 0;
   int failures = 0;
   int edgeNum  = 0;

   pulse_stretcher #(.FRQ(8000), .HOLD_MS(3), .BITS(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .DIN   (DIN),
      .DOUT  (DOUT),
      .ACTIVE(ACTIVE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic nextEdge();
      @(posedge CLK);
      edgeNum++;
      @(negedge CLK);
   endtask

   task automatic doReset();
      DIN   = 4'b0000;
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (DOUT !== 4'b0000 || ACTIVE !== 1'b0) begin
         failures++;
         $display("[TB] FAIL in_reset got DOUT=%b ACTIVE=%b expected DOUT=0000 ACTIVE=0", DOUT, ACTIVE);
      end
      RESET   = 1'b0;
      edgeNum = 0;
   endtask

   // Idle after reset: outputs stay low and the tick fires once every 8 cycles.
   task automatic test_reset();
      logic expTick;
      doReset();
      for (int e = 1; e <= 40; e++) begin
         nextEdge();
         expTick = ((e % 8) == 7);
         checks++;
         if (DOUT !== 4'b0000 || ACTIVE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_outputs edge=%0d got DOUT=%b ACTIVE=%b expected 0000/0", e, DOUT, ACTIVE);
         end
         checks++;
         if (dut.tick !== expTick) begin
            failures++;
            $display("[TB] FAIL idle_tick edge=%0d got %b expected %b", e, dut.tick, expTick);
         end
      end
   endtask

   // One-cycle pulse at edge 2 stays visible until the third tick at edge 24.
   task automatic test_single_pulse();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 30; e++) begin
         DIN = (e == 2) ? 4'b0001 : 4'b0000;
         nextEdge();
         exp = (e >= 2 && e < 24) ? 4'b0001 : 4'b0000;
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL single_pulse edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   // Second pulse at edge 20 reloads the count and extends the hold to edge 40 without a gap.
   task automatic test_retrigger();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 46; e++) begin
         DIN = (e == 2 || e == 20) ? 4'b0001 : 4'b0000;
         nextEdge();
         exp = (e >= 2 && e < 40) ? 4'b0001 : 4'b0000;
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL retrigger edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   // Level held over edges 5..30 blocks decrements; countdown runs on ticks 32, 40, 48.
   task automatic test_held_level();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 54; e++) begin
         DIN = (e >= 5 && e <= 30) ? 4'b0010 : 4'b0000;
         nextEdge();
         exp = (e >= 5 && e < 48) ? 4'b0010 : 4'b0000;
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL held_level edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   // DIN still high on the tick edge 16 reloads instead of decrementing; lane 3 stays quiet.
   task automatic test_reload_wins();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 46; e++) begin
         DIN = (e == 15 || e == 16) ? 4'b0100 : 4'b0000;
         nextEdge();
         exp = (e >= 15 && e < 40) ? 4'b0100 : 4'b0000;
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL reload_wins edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   // Shortest and longest holds on independent lanes, plus a simultaneous all-lane event.
   task automatic test_back_to_back();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 60; e++) begin
         DIN = 4'b0000;
         if (e == 7)  DIN[3] = 1'b1;
         if (e == 8)  DIN[0] = 1'b1;
         if (e == 34) DIN    = 4'b1111;
         nextEdge();
         exp = 4'b0000;
         exp[3] = (e >= 7 && e < 24) || (e >= 34 && e < 56);
         exp[0] = (e >= 8 && e < 32) || (e >= 34 && e < 56);
         exp[1] = (e >= 34 && e < 56);
         exp[2] = (e >= 34 && e < 56);
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL back_to_back edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   // Reset mid-hold clears outputs immediately; afterwards nothing resumes and the tick phase restarts.
   task automatic test_reset_mid_hold();
      logic [3:0] exp;
      doReset();
      for (int e = 1; e <= 10; e++) begin
         DIN = (e == 2) ? 4'b0001 : 4'b0000;
         nextEdge();
      end
      checks++;
      if (DOUT !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL pre_reset_hold got DOUT=%b expected 0001", DOUT);
      end
      RESET = 1'b1;
      #1;
      checks++;
      if (DOUT !== 4'b0000 || ACTIVE !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset got DOUT=%b ACTIVE=%b expected 0000/0", DOUT, ACTIVE);
      end
      repeat (2) @(negedge CLK);
      RESET   = 1'b0;
      edgeNum = 0;
      for (int e = 1; e <= 30; e++) begin
         DIN = (e == 7) ? 4'b0010 : 4'b0000;
         nextEdge();
         exp = (e >= 7 && e < 24) ? 4'b0010 : 4'b0000;
         checks++;
         if (DOUT !== exp || ACTIVE !== (exp != 4'b0000)) begin
            failures++;
            $display("[TB] FAIL after_reset edge=%0d got DOUT=%b ACTIVE=%b expected DOUT=%b ACTIVE=%b",
                     e, DOUT, ACTIVE, exp, (exp != 4'b0000));
         end
      end
      DIN = 4'b0000;
   endtask

   initial begin
      RESET = 1'b1;
      DIN   = 4'b0000;
      test_reset();
      test_single_pulse();
      test_retrigger();
      test_held_level();
      test_reload_wins();
      test_back_to_back();
      test_reset_mid_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
